// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: registered N-way round-robin arbiter with grant hold.
// The owner keeps the resource while it holds its request. Once it has held
// the grant for MAX_HOLD cycles and someone else is waiting, it is pre-empted
// and the grant rotates. A lone requester is never pre-empted.
module rr_hold_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   request,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy
);

  localparam int HCW = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);

  typedef enum logic {IDLE, OWN} state_t;

  state_t         state_q;
  logic [IDW-1:0] owner_q;
  logic [IDW-1:0] ptr_q;
  logic [HCW-1:0] hold_cnt_q;
  logic [N-1:0]   grant_q;
  logic           busy_q;

  // Circular first-set search starting at 'start'. When excl_en is set, index
  // 'excl' is skipped. Returns {found, index}.
  function automatic logic [IDW:0] pick(input logic [N-1:0]   req,
                                        input logic [IDW-1:0] start,
                                        input logic           excl_en,
                                        input logic [IDW-1:0] excl);
    logic           found;
    logic [IDW-1:0] idx;
    int             j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!found && req[j] && !(excl_en && (j == int'(excl)))) begin
        found = 1'b1;
        idx   = j[IDW-1:0];
      end
    end
    return {found, idx};
  endfunction

  // Index after 'idx', wrapping modulo N (N need not be a power of two).
  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
    if (int'(idx) >= N - 1) return '0;
    else                    return idx + IDW'(1);
  endfunction

  // One-hot vector with bit 'idx' set.
  function automatic logic [N-1:0] onehot(input logic [IDW-1:0] idx);
    logic [N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) begin
      if (k == int'(idx)) v[k] = 1'b1;
    end
    return v;
  endfunction

  logic [IDW-1:0] owner_next;
  logic [IDW:0]   sel_idle;
  logic [IDW:0]   sel_other;
  logic           idle_found;
  logic [IDW-1:0] idle_idx;
  logic           other_found;
  logic [IDW-1:0] other_idx;
  logic           owner_req;

  // Candidate selections: from ptr when idle, and from owner+1 (skipping the
  // owner) on release or pre-emption. On release the owner's bit is already
  // low, so one search covers both handover cases.
  always_comb begin
    owner_next  = next_idx(owner_q);
    sel_idle    = pick(request, ptr_q, 1'b0, owner_q);
    sel_other   = pick(request, owner_next, 1'b1, owner_q);
    idle_found  = sel_idle[IDW];
    idle_idx    = sel_idle[IDW-1:0];
    other_found = sel_other[IDW];
    other_idx   = sel_other[IDW-1:0];
    owner_req   = |(request & grant_q);
  end

  // Arbitration FSM with registered grant, owner, busy and tenure counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (idle_found) begin
            state_q    <= OWN;
            owner_q    <= idle_idx;
            grant_q    <= onehot(idle_idx);
            busy_q     <= 1'b1;
            hold_cnt_q <= HCW'(1);
          end
        end
        OWN: begin
          if (!owner_req) begin
            // Release: rotate priority past the owner and hand over at once.
            ptr_q <= owner_next;
            if (other_found) begin
              owner_q    <= other_idx;
              grant_q    <= onehot(other_idx);
              hold_cnt_q <= HCW'(1);
            end else begin
              state_q    <= IDLE;
              grant_q    <= '0;
              busy_q     <= 1'b0;
              hold_cnt_q <= '0;
            end
          end else if ((hold_cnt_q == HOLD_MAX) && other_found) begin
            // Tenure expired with others waiting: pre-empt.
            ptr_q      <= owner_next;
            owner_q    <= other_idx;
            grant_q    <= onehot(other_idx);
            hold_cnt_q <= HCW'(1);
          end else if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_q <= hold_cnt_q + HCW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign grant_id = owner_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed testbench for rr_hold_arbiter with N=4, MAX_HOLD=4.
module tb_rr_hold_arbiter;

  localparam int N = 4;
  localparam int MAX_HOLD = 4;
  localparam int IDW = 2;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   request;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           busy;

  int checks;
  int failures;

  rr_hold_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .request  (request),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    request = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    request = 4'b1111;
    #3;
    checks++;
    if (grant !== 4'b0000) begin
      failures++;
      $display("FAIL reset_grant got=%b want=%b", grant, 4'b0000);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b want=%b", busy, 1'b0);
    end
    checks++;
    if (grant_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_id got=%0d want=%0d", grant_id, 0);
    end
    tick();
    tick();
    checks++;
    if (grant !== 4'b0000) begin
      failures++;
      $display("FAIL reset_hold_grant got=%b want=%b", grant, 4'b0000);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0001 || grant_id !== 2'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_grant got=%b/%0d/%b want=0001/0/1", grant, grant_id, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    request = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0100 || grant_id !== 2'd2 || busy !== 1'b1) begin
        failures++;
        $display("FAIL single_hold[%0d] got=%b/%0d/%b want=0100/2/1", i, grant, grant_id, busy);
      end
    end
    request = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd2) begin
      failures++;
      $display("FAIL single_release got=%b/%0d/%b want=0000/2/0", grant, grant_id, busy);
    end
    request = 4'b1111;
    tick();
    checks++;
    if (grant !== 4'b1000 || grant_id !== 2'd3) begin
      failures++;
      $display("FAIL single_next_ptr got=%b/%0d want=1000/3", grant, grant_id);
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp;
    do_reset();
    request = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      exp = 4'b0001 << g;
      for (int c = 0; c < MAX_HOLD; c++) begin
        tick();
        checks++;
        if (grant !== exp || busy !== 1'b1 || grant_id !== g[IDW-1:0]) begin
          failures++;
          $display("FAIL contention[%0d.%0d] got=%b/%0d want=%b/%0d", g, c, grant, grant_id, exp, g);
        end
      end
    end
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL contention_wrap got=%b want=%b", grant, 4'b0001);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    request = 4'b0001;
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL b2b_first got=%b want=%b", grant, 4'b0001);
    end
    request = 4'b1010;
    tick();
    checks++;
    if (grant !== 4'b0010 || grant_id !== 2'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_handover1 got=%b/%0d/%b want=0010/1/1", grant, grant_id, busy);
    end
    request = 4'b1000;
    tick();
    checks++;
    if (grant !== 4'b1000 || grant_id !== 2'd3 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_handover2 got=%b/%0d/%b want=1000/3/1", grant, grant_id, busy);
    end
  endtask

  task automatic test_uncontended_hold();
    do_reset();
    request = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0001) begin
        failures++;
        $display("FAIL hold[%0d] got=%b want=%b", i, grant, 4'b0001);
      end
    end
    request = 4'b0101;
    #1;
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL hold_extra_cycle got=%b want=%b", grant, 4'b0001);
    end
    tick();
    checks++;
    if (grant !== 4'b0100 || grant_id !== 2'd2) begin
      failures++;
      $display("FAIL hold_preempt got=%b/%0d want=0100/2", grant, grant_id);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    request = 4'b0100;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0100) begin
      failures++;
      $display("FAIL async_pre got=%b want=%b", grant, 4'b0100);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL async_clear got=%b/%0d/%b want=0000/0/0", grant, grant_id, busy);
    end
    request = 4'b1111;
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0001 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL async_regrant got=%b/%0d want=0001/0", grant, grant_id);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    request  = '0;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_uncontended_hold();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
